// File: rtl/sp_arb_pkg.sv
// -----------------------------------------------------------------------------
// sp_arb_pkg
// Shared definitions for the scratch pad arbiter:
//   arb_state_t        - transfer FSM states (IDLE -> STROBE -> CAPTURE -> ACK)
//   SEL_SP1 / SEL_SP2  - encodings of the requester SEL field
//   REQ_ID0 / REQ_ID1  - requester identifiers as carried on GNT
// -----------------------------------------------------------------------------
package sp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_t;

    localparam logic SEL_SP1 = 1'b0;
    localparam logic SEL_SP2 = 1'b1;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/sp_arbiter_if.sv
// -----------------------------------------------------------------------------
// sp_arbiter_if
// Bundles the two requester ports, the scratch pad port and the status outputs
// of the arbiter.
//   modport slave  - the arbiter: takes requests and SP_DO, drives ACK/DO,
//                    scratch pad strobes/write data and status.
//   modport master - the environment: requesters and scratch pads.
// Parameters: DW (data width), CNT_W (transfer counter width).
// -----------------------------------------------------------------------------
interface sp_arbiter_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    // requester side
    logic            REQ0, REQ1;
    logic            WR0,  WR1;
    logic            SEL0, SEL1;
    logic [DW-1:0]   DI0,  DI1;
    logic            ACK0, ACK1;
    logic [DW-1:0]   DO0,  DO1;

    // scratch pad side
    logic [DW-1:0]   SP_DI;
    logic [DW-1:0]   SP_DO;
    logic            SP1_RE, SP1_WE, SP2_RE, SP2_WE;

    // status
    logic            BUSY;
    logic            GNT;
    logic [CNT_W-1:0] XFER_CNT;

    modport slave (
        input  REQ0, REQ1, WR0, WR1, SEL0, SEL1, DI0, DI1, SP_DO,
        output ACK0, ACK1, DO0, DO1, SP_DI,
        output SP1_RE, SP1_WE, SP2_RE, SP2_WE,
        output BUSY, GNT, XFER_CNT
    );

    modport master (
        output REQ0, REQ1, WR0, WR1, SEL0, SEL1, DI0, DI1, SP_DO,
        input  ACK0, ACK1, DO0, DO1, SP_DI,
        input  SP1_RE, SP1_WE, SP2_RE, SP2_WE,
        input  BUSY, GNT, XFER_CNT
    );

endinterface

// File: rtl/sp_arb_picker.sv
// -----------------------------------------------------------------------------
// sp_arb_picker
// Combinational grant selection between the two requesters.
// Ports:
//   req0, req1 - request inputs
//   ptr        - arbitration pointer: requester preferred on a tie
//   winner     - id of the requester to grant (don't-care when no request)
//   ptr_next   - pointer value to store when the grant is taken
// Build option: SP_ARB_ROUND_ROBIN_EN
//   defined   - round-robin: a tie goes to ptr, and the pointer then moves to
//               the requester that lost, so the two alternate.
//   undefined - fixed priority: requester 0 wins every tie; the pointer holds
//               its reset value.
// -----------------------------------------------------------------------------
module sp_arb_picker
    import sp_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner,
    output logic ptr_next
);

`ifdef SP_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = ptr;
        if (req0 && req1) begin
            winner = ptr;
        end else if (req1) begin
            winner = REQ_ID1;
        end else if (req0) begin
            winner = REQ_ID0;
        end
        // The requester that did not win this grant is preferred next time.
        ptr_next = ~winner;
    end
`else
    always_comb begin
        // With no request the result is unused; the pointer is returned.
        winner = ptr;
        if (req0) begin
            winner = REQ_ID0;
        end else if (req1) begin
            winner = REQ_ID1;
        end
        ptr_next = ptr;
    end
`endif

endmodule

// File: rtl/sp_arbiter.sv
// -----------------------------------------------------------------------------
// sp_arbiter
// Arbitrates two requesters onto two single-ported scratch pads. Each transfer
// walks IDLE -> STROBE -> CAPTURE -> ACK, one clock per non-IDLE state.
// Ports:
//   OPB_CLK  - clock, all state changes on its rising edge
//   OPB_RST  - asynchronous active-high reset
//   bus      - sp_arbiter_if.slave: REQx/WRx/SELx/DIx in, ACKx/DOx out,
//              SP_DI/SP1_RE/SP1_WE/SP2_RE/SP2_WE out, SP_DO in,
//              BUSY/GNT/XFER_CNT status out
// Parameters: DW (data width), CNT_W (completed-transfer counter width).
// Build option: SP_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed
// priority on simultaneous requests (see sp_arb_picker).
//
// Timing: GNT and BUSY follow the FSM state directly. The strobe, SP_DI, ACK
// and DO registers are loaded while the FSM is in the matching state, so on
// the pins each of those phases appears one clock after its state. With REQ
// sampled at edge k: strobe high after edge k+1, SP_DO expected in the cycle
// after the strobe, DOx and ACKx updated together after edge k+3.
// -----------------------------------------------------------------------------
module sp_arbiter
    import sp_arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic         OPB_CLK,
    input  logic         OPB_RST,
    sp_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t        state_reg;
    logic              ptr_reg;
    logic              gnt_reg;
    logic              busy_reg;

    // Requester fields latched at grant; later changes on the inputs are
    // ignored for the rest of the transfer.
    logic              wr_reg;
    logic              sel_reg;
    logic [DW-1:0]     di_reg;

    logic              sp1_re_reg, sp1_we_reg, sp2_re_reg, sp2_we_reg;
    logic [DW-1:0]     sp_di_reg;
    logic              ack0_reg, ack1_reg;
    logic [DW-1:0]     do0_reg, do1_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              winner;
    logic              ptr_next;

    sp_arb_picker u_picker (
        .req0     (bus.REQ0),
        .req1     (bus.REQ1),
        .ptr      (ptr_reg),
        .winner   (winner),
        .ptr_next (ptr_next)
    );

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= REQ_ID0;
            gnt_reg    <= REQ_ID0;
            busy_reg   <= 1'b0;
            wr_reg     <= 1'b0;
            sel_reg    <= SEL_SP1;
            di_reg     <= '0;
            sp1_re_reg <= 1'b0;
            sp1_we_reg <= 1'b0;
            sp2_re_reg <= 1'b0;
            sp2_we_reg <= 1'b0;
            sp_di_reg  <= '0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;
            do0_reg    <= '0;
            do1_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            // Pulsed outputs fall back to zero unless their state reloads them.
            sp1_re_reg <= 1'b0;
            sp1_we_reg <= 1'b0;
            sp2_re_reg <= 1'b0;
            sp2_we_reg <= 1'b0;
            sp_di_reg  <= '0;
            ack0_reg   <= 1'b0;
            ack1_reg   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (bus.REQ0 || bus.REQ1) begin
                        gnt_reg   <= winner;
                        ptr_reg   <= ptr_next;
                        wr_reg    <= (winner == REQ_ID1) ? bus.WR1  : bus.WR0;
                        sel_reg   <= (winner == REQ_ID1) ? bus.SEL1 : bus.SEL0;
                        di_reg    <= (winner == REQ_ID1) ? bus.DI1  : bus.DI0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_STROBE;
                    end
                end

                ST_STROBE: begin
                    sp1_re_reg <= !wr_reg && (sel_reg == SEL_SP1);
                    sp1_we_reg <=  wr_reg && (sel_reg == SEL_SP1);
                    sp2_re_reg <= !wr_reg && (sel_reg == SEL_SP2);
                    sp2_we_reg <=  wr_reg && (sel_reg == SEL_SP2);
                    sp_di_reg  <= di_reg;
                    state_reg  <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    // Keep write data stable for the cycle after the strobe.
                    sp_di_reg <= di_reg;
                    state_reg <= ST_ACK;
                end

                ST_ACK: begin
                    // SP_DO is valid in the cycle after the strobe pulse, i.e.
                    // while the FSM is here; capture it on the edge that also
                    // raises ACK so DOx is already valid when ACKx is seen.
                    if (!wr_reg) begin
                        if (gnt_reg == REQ_ID1) begin
                            do1_reg <= bus.SP_DO;
                        end else begin
                            do0_reg <= bus.SP_DO;
                        end
                    end
                    ack0_reg  <= (gnt_reg == REQ_ID0);
                    ack1_reg  <= (gnt_reg == REQ_ID1);
                    cnt_reg   <= cnt_reg + CNT_ONE;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SP1_RE   = sp1_re_reg;
    assign bus.SP1_WE   = sp1_we_reg;
    assign bus.SP2_RE   = sp2_re_reg;
    assign bus.SP2_WE   = sp2_we_reg;
    assign bus.SP_DI    = sp_di_reg;
    assign bus.ACK0     = ack0_reg;
    assign bus.ACK1     = ack1_reg;
    assign bus.DO0      = do0_reg;
    assign bus.DO1      = do1_reg;
    assign bus.BUSY     = busy_reg;
    assign bus.GNT      = gnt_reg;
    assign bus.XFER_CNT = cnt_reg;

endmodule
